idecoder_queue: RTL and testbench

- Parametrised successor to the single-instruction decoder. Buffers raw 16-bit instruction words from fetch in a DEPTH-entry FIFO and decodes the head entry.
- Presents the decoded fields to the controller FSM behind a valid/ready handshake.
- Sign-extended immediates are DATA_W wide, so the same decoder serves the 16-bit and wider datapath builds.
- Supports a flush for branch redirect.

---
 rtl/idecoder_queue.sv | 100 ++++++++++
 tb/tb_idecoder_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idecoder_queue.sv
// Instruction queue with head-entry decode: buffers raw 16-bit words from fetch and
// presents the decoded head to the controller behind a valid/ready handshake.
module idecoder_queue #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                ir_in,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic [1:0]                 reg_sel,
    output logic [2:0]                 opcode,
    output logic [1:0]                 ALU_op,
    output logic [1:0]                 shift_op,
    output logic [DATA_W-1:0]          sximm5,
    output logic [DATA_W-1:0]          sximm8,
    output logic [2:0]                 r_addr,
    output logic [2:0]                 w_addr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [15:0]   head;
    logic [2:0]    sel_addr;

    // Handshake flags come from registered occupancy only, so in_ready never sees out_ready.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: its contents only reach the outputs through the valid gate.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= ir_in;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : 16'h0000;

    always_comb begin
        sel_addr = 3'b000;
        case (reg_sel)
            2'b00:   sel_addr = head[2:0];
            2'b01:   sel_addr = head[7:5];
            2'b10:   sel_addr = head[10:8];
            default: sel_addr = 3'b000;
        endcase
    end

    assign opcode   = head[15:13];
    assign ALU_op   = head[12:11];
    assign shift_op = head[4:3];
    assign sximm5   = {{(DATA_W-5){head[4]}}, head[4:0]};
    assign sximm8   = {{(DATA_W-8){head[7]}}, head[7:0]};
    assign r_addr   = sel_addr;
    assign w_addr   = sel_addr;

endmodule

// File: tb/tb_idecoder_queue.sv
// Bench for idecoder_queue: a queue-based reference model predicts every decoded output
// cycle by cycle; a second instance covers the 32-bit immediate build.
module tb_idecoder_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int VW    = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [15:0] ir_in;
    logic [1:0]  reg_sel;
    logic        in_ready, out_valid;
    logic [2:0]  opcode, r_addr, w_addr;
    logic [1:0]  ALU_op, shift_op;
    logic [15:0] sximm5, sximm8;
    logic [CW-1:0] count;

    logic        w_in_valid, w_out_ready;
    logic [15:0] w_ir_in;
    logic        w_in_ready, w_out_valid;
    logic [2:0]  w_opcode, w_r_addr, w_w_addr;
    logic [1:0]  w_ALU_op, w_shift_op;
    logic [31:0] w_sximm5, w_sximm8;
    logic [CW-1:0] w_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mq[$];

    always #5 clk = ~clk;

    idecoder_queue #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ir_in(ir_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .reg_sel(reg_sel),
        .opcode(opcode), .ALU_op(ALU_op), .shift_op(shift_op), .sximm5(sximm5),
        .sximm8(sximm8), .r_addr(r_addr), .w_addr(w_addr), .count(count)
    );

    idecoder_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .ir_in(w_ir_in),
        .flush(1'b0), .out_valid(w_out_valid), .out_ready(w_out_ready), .reg_sel(2'b00),
        .opcode(w_opcode), .ALU_op(w_ALU_op), .shift_op(w_shift_op), .sximm5(w_sximm5),
        .sximm8(w_sximm8), .r_addr(w_r_addr), .w_addr(w_w_addr), .count(w_count)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (count > CW'(DEPTH) || w_count > CW'(DEPTH))) begin
            $display("FAIL count_bound: count=%0d wide_count=%0d exceeds %0d", count, w_count, DEPTH);
            miscompares++;
        end
    end

    function automatic logic [VW-1:0] obs_vec();
        return {out_valid, in_ready, count, opcode, ALU_op, shift_op, sximm5, sximm8, r_addr, w_addr};
    endfunction

    // Expected outputs straight from the field definitions applied to the model's head word.
    function automatic logic [VW-1:0] model_vec(input logic [1:0] sel);
        logic [15:0] w;
        logic        v;
        logic [2:0]  a;
        v = (mq.size() != 0);
        w = v ? mq[0] : 16'h0000;
        case (sel)
            2'd0:    a = w[2:0];
            2'd1:    a = w[7:5];
            2'd2:    a = w[10:8];
            default: a = 3'd0;
        endcase
        return {v, mq.size() != DEPTH, CW'(mq.size()), w[15:13], w[12:11], w[4:3],
                {{11{w[4]}}, w[4:0]}, {{8{w[7]}}, w[7:0]}, a, a};
    endfunction

    task automatic do_cycle();
        bit pu, po;
        pu = in_valid && (mq.size() < DEPTH);
        po = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(ir_in);
        end
        #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        in_valid = 1'b1; ir_in = w; out_ready = 1'b0;
        do_cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mq.delete();
        #7;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; reg_sel = 2'b00; ir_in = 16'hFFFF;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_ir_in = 16'h0000;
        rst_n = 1'b0; mq.delete();
        #12;
        vectors++;
        if (obs_vec() !== {1'b0, 1'b1, 48'b0}) begin
            $display("FAIL reset_state: got %h expected %h", obs_vec(), {1'b0, 1'b1, 48'b0});
            miscompares++;
        end
        @(posedge clk); #1; rst_n = 1'b1;
        push_word(16'h3333);
        vectors++;
        if ({out_valid, opcode, ALU_op, shift_op, sximm8, sximm5} !==
            {1'b1, 3'b001, 2'b10, 2'b10, 16'h0033, 16'hFFF3}) begin
            $display("FAIL single_decode: got %h expected %h",
                     {out_valid, opcode, ALU_op, shift_op, sximm8, sximm5},
                     {1'b1, 3'b001, 2'b10, 2'b10, 16'h0033, 16'hFFF3});
            miscompares++;
        end
    endtask

    task automatic test_reg_sel();
        logic [2:0] exp_a [4];
        exp_a[0] = 3'b011; exp_a[1] = 3'b001; exp_a[2] = 3'b011; exp_a[3] = 3'b000;
        for (int s = 0; s < 4; s++) begin
            reg_sel = 2'(s);
            #1;
            vectors++;
            if ({r_addr, w_addr} !== {exp_a[s], exp_a[s]}) begin
                $display("FAIL reg_sel_%0d: got r=%b w=%b expected %b", s, r_addr, w_addr, exp_a[s]);
                miscompares++;
            end
        end
        out_ready = 1'b1; do_cycle();
        push_word(16'h0520);
        reg_sel = 2'b10; #1;
        vectors++;
        if ({r_addr, w_addr} !== {3'b101, 3'b101}) begin
            $display("FAIL reg_sel_rn_0520: got r=%b w=%b expected 101", r_addr, w_addr);
            miscompares++;
        end
        out_ready = 1'b1; do_cycle();
    endtask

    task automatic test_fill();
        logic [15:0] words [4];
        logic [2:0]  ops [4];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h4444; words[3] = 16'h8888;
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100;
        reg_sel = 2'b00;
        for (int i = 0; i < 4; i++) push_word(words[i]);
        vectors++;
        if ({count, in_ready} !== {3'd4, 1'b0}) begin
            $display("FAIL fill_full: got count=%0d in_ready=%b expected 4/0", count, in_ready);
            miscompares++;
        end
        push_word(16'hFFFF);
        vectors++;
        if (obs_vec() !== model_vec(reg_sel) || count !== 3'd4) begin
            $display("FAIL fifth_push: got %h expected %h", obs_vec(), model_vec(reg_sel));
            miscompares++;
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({out_valid, opcode} !== {1'b1, ops[i]}) begin
                $display("FAIL drain_%0d: got valid=%b opcode=%b expected 1/%b", i, out_valid, opcode, ops[i]);
                miscompares++;
            end
            out_ready = 1'b1; do_cycle();
        end
        vectors++;
        if (obs_vec() !== {1'b0, 1'b1, 48'b0}) begin
            $display("FAIL drain_empty: got %h expected %h", obs_vec(), {1'b0, 1'b1, 48'b0});
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        push_word(16'($urandom));
        push_word(16'($urandom));
        for (int i = 0; i < 3 * DEPTH; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; ir_in = 16'($urandom);
            reg_sel = 2'($urandom_range(0, 3));
            do_cycle();
            vectors++;
            if (obs_vec() !== model_vec(reg_sel) || count !== 3'd2) begin
                $display("FAIL back_to_back_%0d: got %h expected %h", i, obs_vec(), model_vec(reg_sel));
                miscompares++;
            end
        end
        out_ready = 1'b1; do_cycle();
        out_ready = 1'b1; do_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 19) == 0);
            ir_in     = 16'($urandom);
            reg_sel   = 2'($urandom_range(0, 3));
            do_cycle();
            vectors++;
            if (obs_vec() !== model_vec(reg_sel)) begin
                $display("FAIL random_%0d: got %h expected %h", i, obs_vec(), model_vec(reg_sel));
                miscompares++;
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        reg_sel = 2'b00;
        push_word(16'h2001); push_word(16'h4002); push_word(16'h6003);
        in_valid = 1'b1; ir_in = 16'hBEEF; flush = 1'b1; out_ready = 1'b1;
        do_cycle();
        vectors++;
        if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            $display("FAIL flush_clear: got count=%0d valid=%b ready=%b expected 0/0/1", count, out_valid, in_ready);
            miscompares++;
        end
        push_word(16'hA5C3);
        vectors++;
        if ({count, opcode, sximm8} !== {3'd1, 3'b101, 16'hFFC3}) begin
            $display("FAIL flush_no_ghost: got count=%0d op=%b imm8=%h expected 1/101/ffc3", count, opcode, sximm8);
            miscompares++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        reg_sel = 2'b01;
        push_word(16'hE7F5); push_word(16'h1234);
        @(negedge clk); #2;
        rst_n = 1'b0; mq.delete();
        #1;
        vectors++;
        if (obs_vec() !== {1'b0, 1'b1, 48'b0}) begin
            $display("FAIL async_reset: got %h expected %h", obs_vec(), {1'b0, 1'b1, 48'b0});
            miscompares++;
        end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_wide();
        w_in_valid = 1'b1; w_ir_in = 16'h3333; w_out_ready = 1'b0;
        @(posedge clk); #1; w_in_valid = 1'b0;
        vectors++;
        if ({w_out_valid, w_sximm5, w_sximm8} !== {1'b1, 32'hFFFFFFF3, 32'h00000033}) begin
            $display("FAIL wide_3333: got v=%b imm5=%h imm8=%h expected 1/fffffff3/00000033", w_out_valid, w_sximm5, w_sximm8);
            miscompares++;
        end
        w_out_ready = 1'b1; w_in_valid = 1'b1; w_ir_in = 16'h0080;
        @(posedge clk); #1; w_out_ready = 1'b0; w_in_valid = 1'b0;
        vectors++;
        if ({w_count, w_sximm5, w_sximm8} !== {3'd1, 32'h00000000, 32'hFFFFFF80}) begin
            $display("FAIL wide_0080: got cnt=%0d imm5=%h imm8=%h expected 1/00000000/ffffff80", w_count, w_sximm5, w_sximm8);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_reg_sel();
        test_fill();
        test_back_to_back();
        test_random();
        test_flush();
        test_async_reset();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
